key_fragment_sequencer: RTL



---
 rtl/tcam_frag_pkg.sv | 27 ++
 rtl/key_fragment_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tcam_frag_pkg.sv
`default_nettype none
// ============================================================================
// Module : tcam_frag_pkg
// Brief  : Shared fragment/segment-address widths, FSM encodings and address
//          packing helper for the key fragment path.
// Rev    : 1.0  initial release
// ============================================================================
package tcam_frag_pkg;

    localparam int unsigned C_DATA_BITS = 10;
    localparam int unsigned C_FRAGMENTS = 5;
    localparam int unsigned C_FRAG_BITS = 3;
    localparam int unsigned C_FRAG_WID  = C_DATA_BITS / C_FRAGMENTS;
    localparam int unsigned C_ADDR_WID  = C_FRAG_BITS + C_FRAG_WID;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    function automatic logic [C_ADDR_WID-1:0] pack_frag_addr(
        input logic [C_FRAG_BITS-1:0] index,
        input logic [C_FRAG_WID-1:0]  fragment
    );
        return {index, fragment};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fragment_sequencer.sv
`default_nettype none
// ============================================================================
// Module : key_fragment_sequencer
// Brief  : Splits each accepted search key into indexed fragment keys, one per
//          cycle, tagged per key with a last-fragment marker.
// Rev    : 1.0  initial release
// ============================================================================
module key_fragment_sequencer
    import tcam_frag_pkg::*;
#(
    parameter int DATA_BITS = C_DATA_BITS,
    parameter int FRAGMENTS = C_FRAGMENTS,
    parameter int FRAG_BITS = C_FRAG_BITS,
    parameter int TAG_BITS  = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      i_key_valid,
    output logic                                      o_key_ready,
    input  logic [DATA_BITS-1:0]                      i_key,
    output logic                                      o_frag_valid,
    input  logic                                      i_frag_ready,
    output logic [FRAG_BITS+DATA_BITS/FRAGMENTS-1:0]  o_fragment_key,
    output logic                                      o_frag_last,
    output logic [TAG_BITS-1:0]                       o_frag_tag,
    output logic                                      o_busy
);

    localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
    localparam int ADDR_WID = FRAG_BITS + FRAG_WID;
    localparam logic [FRAG_BITS-1:0] C_LAST_IDX = FRAG_BITS'(FRAGMENTS - 1);

    if (DATA_BITS % FRAGMENTS != 0) begin : g_bad_split
        $error("DATA_BITS must be a multiple of FRAGMENTS");
    end
    if (FRAGMENTS > (2 ** FRAG_BITS)) begin : g_bad_index
        $error("FRAGMENTS does not fit in FRAG_BITS");
    end

    logic [0:0]           r_state_q, w_state_d;
    logic [DATA_BITS-1:0] r_key_q,   w_key_d;
    logic [FRAG_BITS-1:0] r_idx_q,   w_idx_d;
    logic [TAG_BITS-1:0]  r_tcnt_q,  w_tcnt_d;
    logic [ADDR_WID-1:0]  r_fkey_q,  w_fkey_d;
    logic [TAG_BITS-1:0]  r_tag_q,   w_tag_d;
    logic                 r_last_q,  w_last_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_ready_q, w_ready_d;
    logic                 r_busy_q,  w_busy_d;

    logic                 w_accept, w_hs, w_done;
    logic [FRAG_BITS-1:0] w_idx_nxt;
    logic [DATA_BITS-1:0] w_key_src;
    logic [FRAG_WID-1:0]  w_frag_nxt;

    assign w_accept = (r_state_q == S_IDLE) && i_key_valid;
    assign w_hs     = r_valid_q && i_frag_ready;
    assign w_done   = w_hs && r_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (i_key_valid) w_state_d = S_ISSUE;
            S_ISSUE: if (w_done)      w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // The fragment for the next index is pre-selected so every output can be
    // loaded straight into its register on the acceptance or handshake edge.
    always_comb begin
        w_idx_nxt  = w_accept ? '0 : r_idx_q + FRAG_BITS'(1);
        w_key_src  = w_accept ? i_key : r_key_q;
        w_frag_nxt = '0;
        for (int f = 0; f < FRAGMENTS; f++) begin
            if (w_idx_nxt == FRAG_BITS'(f)) begin
                w_frag_nxt = w_key_src[f*FRAG_WID +: FRAG_WID];
            end
        end

        w_key_d   = r_key_q;
        w_idx_d   = r_idx_q;
        w_tcnt_d  = r_tcnt_q;
        w_fkey_d  = r_fkey_q;
        w_tag_d   = r_tag_q;
        w_last_d  = r_last_q;
        w_valid_d = r_valid_q;
        w_ready_d = r_ready_q;
        w_busy_d  = r_busy_q;

        if (w_accept) begin
            w_key_d   = i_key;
            w_idx_d   = w_idx_nxt;
            w_fkey_d  = {w_idx_nxt, w_frag_nxt};
            w_last_d  = (w_idx_nxt == C_LAST_IDX);
            w_tag_d   = r_tcnt_q;
            w_tcnt_d  = r_tcnt_q + TAG_BITS'(1);
            w_valid_d = 1'b1;
            w_ready_d = 1'b0;
            w_busy_d  = 1'b1;
        end else if (w_done) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            w_ready_d = 1'b1;
            w_busy_d  = 1'b0;
        end else if (w_hs) begin
            w_idx_d   = w_idx_nxt;
            w_fkey_d  = {w_idx_nxt, w_frag_nxt};
            w_last_d  = (w_idx_nxt == C_LAST_IDX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q   <= '0;
            r_idx_q   <= '0;
            r_tcnt_q  <= '0;
            r_fkey_q  <= '0;
            r_tag_q   <= '0;
            r_last_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_ready_q <= 1'b1;
            r_busy_q  <= 1'b0;
        end else begin
            r_key_q   <= w_key_d;
            r_idx_q   <= w_idx_d;
            r_tcnt_q  <= w_tcnt_d;
            r_fkey_q  <= w_fkey_d;
            r_tag_q   <= w_tag_d;
            r_last_q  <= w_last_d;
            r_valid_q <= w_valid_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign o_key_ready    = r_ready_q;
    assign o_frag_valid   = r_valid_q;
    assign o_fragment_key = r_fkey_q;
    assign o_frag_last    = r_last_q;
    assign o_frag_tag     = r_tag_q;
    assign o_busy         = r_busy_q;

endmodule
`default_nettype wire
